// File: rtl/add_accum_pkg.sv
// Shared definitions for the add_accum block: operand modes and the layout of
// the registered result.
package add_accum_pkg;

  typedef enum logic {
    MODE_LOAD = 1'b0,
    MODE_ACC  = 1'b1
  } mode_e;

  // Output register layout, MSB first: {carry, ch, sum}.
  function automatic int res_width(input int width, input int ch_w);
    return 1 + ch_w + width;
  endfunction

endpackage

// File: rtl/add_accum_alu.sv
// Combinational WIDTH-bit adder with carry-out. Defining ADD_SAT_EN clamps an
// overflowing sum to all-ones; otherwise the sum wraps modulo 2^WIDTH.
module add_accum_alu #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_carry
);

  logic [WIDTH:0] w_full;

  assign w_full  = {1'b0, i_a} + {1'b0, i_b};
  assign o_carry = w_full[WIDTH];

`ifdef ADD_SAT_EN
  assign o_sum = w_full[WIDTH] ? {WIDTH{1'b1}} : w_full[WIDTH-1:0];
`else
  assign o_sum = w_full[WIDTH-1:0];
`endif

endmodule

// File: rtl/add_accum.sv
// Multi-channel adder/accumulator with a single-entry valid/ready output stage.
// Saturating arithmetic is selected by defining ADD_SAT_EN (see add_accum_alu).
module add_accum
  import add_accum_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [CH_W-1:0]  in_ch,
  input  logic             in_mode,
  input  logic             clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_carry,
  output logic [CH_W-1:0]  out_ch
);

  localparam int RES_W = res_width(WIDTH, CH_W);

  logic [WIDTH-1:0] r_acc [CHANNELS];
  logic [RES_W-1:0] r_res;
  logic             r_out_valid;

  logic             w_accept;
  logic [CH_W-1:0]  w_ch;
  logic [WIDTH-1:0] w_acc_rd;
  logic [WIDTH-1:0] w_opb;
  logic [WIDTH-1:0] w_sum;
  logic             w_carry;

  assign in_ready = !r_out_valid || out_ready;
  assign w_accept = in_valid && in_ready;

  // Channels beyond the array alias to channel 0 for read, write and out_ch.
  assign w_ch = (32'(in_ch) < CHANNELS) ? in_ch : '0;

  // clr makes the ACC operand read as zero in the same cycle.
  assign w_acc_rd = clr ? '0 : r_acc[w_ch];
  assign w_opb    = (in_mode == MODE_ACC) ? w_acc_rd : in_b;

  add_accum_alu #(
    .WIDTH (WIDTH)
  ) u_alu (
    .i_a     (in_a),
    .i_b     (w_opb),
    .o_sum   (w_sum),
    .o_carry (w_carry)
  );

  // The accepted channel takes the new result even when clr wipes the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CHANNELS; i++) r_acc[i] <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (w_accept && (w_ch == CH_W'(i))) r_acc[i] <= w_sum;
        else if (clr)                       r_acc[i] <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_res       <= '0;
      r_out_valid <= 1'b0;
    end else if (w_accept) begin
      r_res       <= {w_carry, w_ch, w_sum};
      r_out_valid <= 1'b1;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid                   = r_out_valid;
  assign {out_carry, out_ch, out_sum} = r_res;

endmodule

// File: tb/tb_add_accum.sv
// Scoreboard bench for add_accum (WIDTH=8, CHANNELS=4); expectations follow
// the wrap build unless ADD_SAT_EN is defined.
module tb_add_accum;

  localparam int WIDTH    = 8;
  localparam int CHANNELS = 4;
  localparam int CH_W     = 2;

  typedef struct packed {
    logic             carry;
    logic [CH_W-1:0]  ch;
    logic [WIDTH-1:0] sum;
  } res_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [CH_W-1:0]  in_ch;
  logic             in_mode;
  logic             clr;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_carry;
  logic [CH_W-1:0]  out_ch;

  int   checks = 0;
  int   errors = 0;
  res_t exp_q[$];

  add_accum #(
    .WIDTH    (WIDTH),
    .CHANNELS (CHANNELS)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_ch     (in_ch),
    .in_mode   (in_mode),
    .clr       (clr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_carry (out_carry),
    .out_ch    (out_ch)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Monitor: every transfer on the output is popped and compared.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_result: got sum=%0d carry=%0d ch=%0d, expected none",
                   out_sum, out_carry, out_ch);
        end else begin
          res_t e;
          e = exp_q.pop_front();
          if (out_sum !== e.sum || out_carry !== e.carry || out_ch !== e.ch) begin
            errors++;
            $display("FAIL result: got sum=%0d carry=%0d ch=%0d, expected sum=%0d carry=%0d ch=%0d",
                     out_sum, out_carry, out_ch, e.sum, e.carry, e.ch);
          end else begin
            $display("t=%0t result sum=%0d carry=%0d ch=%0d ok", $time, out_sum, out_carry, out_ch);
          end
        end
      end
    end
  end

  // Drive one beat, optionally push its expected result, return cycles stalled.
  task automatic send(input logic mode, input logic [CH_W-1:0] ch,
                      input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                      input logic [WIDTH-1:0] es, input logic ec,
                      input bit push, output int waits);
    res_t e;
    in_valid = 1'b1;
    in_mode  = mode;
    in_ch    = ch;
    in_a     = a;
    in_b     = b;
    if (push) begin
      e.carry = ec;
      e.ch    = ch;
      e.sum   = es;
      exp_q.push_back(e);
    end
    waits = 0;
    @(negedge clk);
    while (!in_ready && waits < 50) begin
      waits++;
      @(negedge clk);
    end
    if (!in_ready) begin
      errors++;
      $display("FAIL accept_timeout: got in_ready=0 after %0d cycles, expected 1", waits);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int   w;
    res_t e;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_ch     = '0;
    in_mode   = 1'b0;
    clr       = 1'b0;
    out_ready = 1'b1;

    #12;
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_out_sum",   int'(out_sum),   0);
    check("reset_out_carry", int'(out_carry), 0);
    check("reset_out_ch",    int'(out_ch),    0);
    check("reset_in_ready",  int'(in_ready),  1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // LOAD then three back-to-back ACC beats on channel 0.
    send(1'b0, 2'd0, 8'd10, 8'd20, 8'd30, 1'b0, 1'b1, w);
    send(1'b1, 2'd0, 8'd5, 8'd99, 8'd35, 1'b0, 1'b1, w);
    check("b2b_stall_1", w, 0);
    send(1'b1, 2'd0, 8'd5, 8'd0, 8'd40, 1'b0, 1'b1, w);
    check("b2b_stall_2", w, 0);
    send(1'b1, 2'd0, 8'd5, 8'd0, 8'd45, 1'b0, 1'b1, w);
    check("b2b_stall_3", w, 0);

    // Overflow on channel 1, then accumulate on top of it.
`ifdef ADD_SAT_EN
    send(1'b0, 2'd1, 8'd200, 8'd100, 8'd255, 1'b1, 1'b1, w);
    send(1'b1, 2'd1, 8'd1, 8'd0, 8'd255, 1'b1, 1'b1, w);
`else
    send(1'b0, 2'd1, 8'd200, 8'd100, 8'd44, 1'b1, 1'b1, w);
    send(1'b1, 2'd1, 8'd1, 8'd0, 8'd45, 1'b0, 1'b1, w);
`endif
    idle(2);

    // Backpressure: one held result, one pending beat.
    out_ready = 1'b0;
    send(1'b0, 2'd2, 8'd50, 8'd0, 8'd50, 1'b0, 1'b1, w);
    in_valid = 1'b1;
    in_mode  = 1'b0;
    in_ch    = 2'd3;
    in_a     = 8'd9;
    in_b     = 8'd0;
    e.carry  = 1'b0;
    e.ch     = 2'd3;
    e.sum    = 8'd9;
    exp_q.push_back(e);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_in_ready", int'(in_ready), 0);
      check("hold_out_sum",  int'(out_sum),  50);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    check("drain_in_ready", int'(in_ready), 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;

    // clr together with an ACC beat on channel 2 (acc2=50, acc3=9 before).
    clr = 1'b1;
    send(1'b1, 2'd2, 8'd7, 8'd0, 8'd7, 1'b0, 1'b1, w);
    clr = 1'b0;
    send(1'b1, 2'd3, 8'd1, 8'd0, 8'd1, 1'b0, 1'b1, w);
    send(1'b1, 2'd2, 8'd0, 8'd0, 8'd7, 1'b0, 1'b1, w);
    send(1'b1, 2'd1, 8'd0, 8'd0, 8'd0, 1'b0, 1'b1, w);
    idle(2);

    // Asynchronous reset while a result is held.
    out_ready = 1'b0;
    send(1'b0, 2'd0, 8'd1, 8'd2, 8'd3, 1'b0, 1'b0, w);
    check("held_before_reset", int'(out_valid), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_out_valid", int'(out_valid), 0);
    check("async_reset_out_sum",   int'(out_sum),   0);
    check("async_reset_in_ready",  int'(in_ready),  1);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    send(1'b1, 2'd0, 8'd3, 8'd0, 8'd3, 1'b0, 1'b1, w);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL global_timeout: got time %0t, expected completion", $time);
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

endmodule
